// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module   : mux4_rr_arbiter (with leaf MUX_4)
// Purpose  : Four-way round-robin arbiter steering a shared MUX_4 onto y.
//            Optional hold-timeout preemption enabled by `ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module MUX_4 (
    input  logic [3:0] I,
    input  logic [1:0] S,
    output logic       Y
);
    assign Y = I[S];
endmodule

module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       y
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
        $error("HOLD_MAX must lie in 2..255");
    end

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [1:0] own_q,   own_d;
    logic [3:0] gnt_q,   gnt_d;
    logic       busy_q,  busy_d;

    logic [3:0] w_others;
    logic [3:0] w_pool;
    logic [1:0] w_win;
    logic       w_take;
    logic       w_timeout;
    logic       w_mux_y;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // First set bit of r scanning start, start+1, ... (mod 4); scanning
    // backwards lets the earliest candidate overwrite later ones.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        w_take    = 1'b0;
        w_others  = req & ~(4'b0001 << own_q);
        w_pool    = (state_q == S_GRANT) ? w_others : req;
        w_win     = rr_pick(w_pool, ptr_q);
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        w_timeout = (cnt_q == C_HOLD_LAST) && (|w_others);
`else
        w_timeout = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (|req) w_take = 1'b1;
            end
            S_GRANT: begin
                if (!req[own_q] || w_timeout) begin
                    if (|w_others) begin
                        w_take = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q != C_HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase

        if (w_take) begin
            state_d = S_GRANT;
            own_d   = w_win;
            gnt_d   = 4'b0001 << w_win;
            ptr_d   = w_win + 2'd1;
            busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            own_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    MUX_4 u_mux (
        .I (d),
        .S (own_q),
        .Y (w_mux_y)
    );

    assign gnt  = gnt_q;
    assign sel  = own_q;
    assign busy = busy_q;
    assign y    = busy_q & w_mux_y;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Purpose  : Directed and random checks of mux4_rr_arbiter against a
//            behavioural round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int C_HOLD = 4;
`else
    localparam int C_HOLD = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] d   = 4'b1111;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;

    int n_checks = 0;
    int n_fails  = 0;

    // behavioural model: who owns the line, where the next search starts,
    // and how many cycles the owner has had the line so far
    bit m_busy = 0;
    int m_own  = 0;
    int m_ptr  = 0;
    int m_held = 0;

    mux4_rr_arbiter #(.HOLD_MAX(C_HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .d    (d),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .y    (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    task automatic m_grant(input int w);
        m_busy = 1;
        m_own  = w;
        m_ptr  = (w + 1) % 4;
        m_held = 1;
    endtask

    task automatic m_reset();
        m_busy = 0; m_own = 0; m_ptr = 0; m_held = 0;
    endtask

    task automatic m_edge(input logic [3:0] r);
        logic [3:0] others;
        bit         preempt;
        if (!m_busy) begin
            if (r != 0) m_grant(m_pick(r));
        end else begin
            others = r;
            others[m_own] = 1'b0;
            preempt = 0;
`ifdef ARB_TIMEOUT_EN
            preempt = (m_held >= C_HOLD) && (others != 0);
`endif
            if (!r[m_own] || preempt) begin
                if (others != 0) m_grant(m_pick(others));
                else m_busy = 0;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] eg;
        eg = m_busy ? 4'(1 << m_own) : 4'b0000;
        chk({tag, ".gnt"},  32'(gnt),  32'(eg));
        chk({tag, ".sel"},  32'(sel),  32'(m_own));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".y"},    32'(y),    32'(m_busy & d[m_own]));
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] dv, input string tag);
        req = r;
        d   = dv;
        @(posedge clk);
        m_edge(r);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        req = 4'b0000;
        #1;
        m_reset();
        check_all("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("inv.onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (gnt != 4'b0000) chk("inv.sel", 32'(gnt[sel]), 32'd1);
        end
    end

    initial begin
        int order[$];
        int last;
        int held;
        logic [3:0] r;

        // reset state with all data bits high so y is observable
        #3;
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.sel", 32'(sel), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.y", 32'(y), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // single request, y follows d[2] only
        step(4'b0100, 4'b0000, "single");
        chk("single.gnt", 32'(gnt), 32'b0100);
        chk("single.sel", 32'(sel), 32'd2);
        d = 4'b0100; #1 chk("single.y1", 32'(y), 32'd1);
        d = 4'b1011; #1 chk("single.y0", 32'(y), 32'd0);
        d = 4'b1111; #1 chk("single.y1b", 32'(y), 32'd1);
        step(4'b0000, 4'b1111, "single.drop");
        chk("single.idle", 32'(gnt), 32'd0);

        // all requesting, each owner lets go after three cycles
        do_reset();
        r = 4'b1111;
        last = -1;
        held = 0;
        for (int c = 0; c < 20; c++) begin
            step(r, 4'($urandom), "all");
            if (c > 0) chk("all.busy", 32'(busy), 32'd1);
            if (int'(sel) != last) begin
                order.push_back(int'(sel));
                last = int'(sel);
                held = 0;
            end
            held++;
            r = 4'b1111;
            if (held == 3) r[sel] = 1'b0;
        end
        chk("all.order0", 32'(order[0]), 32'd0);
        chk("all.order1", 32'(order[1]), 32'd1);
        chk("all.order2", 32'(order[2]), 32'd2);
        chk("all.order3", 32'(order[3]), 32'd3);
        chk("all.order4", 32'(order[4]), 32'd0);

        // asynchronous reset while index 1 owns the line
        do_reset();
        step(4'b0010, 4'b0010, "arst.pre");
        chk("arst.gnt_pre", 32'(gnt), 32'b0010);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("arst.gnt", 32'(gnt), 32'd0);
        chk("arst.sel", 32'(sel), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        step(4'b1010, 4'b0000, "arst.post");
        chk("arst.post_gnt", 32'(gnt), 32'b0010);

        // fairness: 3 releases to 0, then 1 and 2 go before 3 again
        do_reset();
        step(4'b1000, 4'b0000, "fair");
        step(4'b1001, 4'b0000, "fair");
        step(4'b0001, 4'b0000, "fair");
        chk("fair.to0", 32'(gnt), 32'b0001);
        step(4'b1111, 4'b0000, "fair");
        step(4'b1110, 4'b0000, "fair");
        chk("fair.to1", 32'(gnt), 32'b0010);
        step(4'b1100, 4'b0000, "fair");
        chk("fair.to2", 32'(gnt), 32'b0100);
        step(4'b1000, 4'b0000, "fair");
        chk("fair.to3", 32'(gnt), 32'b1000);

`ifdef ARB_TIMEOUT_EN
        // preemption after HOLD_MAX cycles while another waits
        do_reset();
        step(4'b0001, 4'b0000, "tmo");
        for (int c = 0; c < 3; c++) begin
            step(4'b0011, 4'b0000, "tmo");
            chk("tmo.hold", 32'(gnt), 32'b0001);
        end
        step(4'b0011, 4'b0000, "tmo");
        chk("tmo.switch", 32'(gnt), 32'b0010);

        // no competitor: grant is never taken away
        do_reset();
        for (int c = 0; c < 11; c++) begin
            step(4'b0001, 4'b0000, "tmo.alone");
            chk("tmo.alone_gnt", 32'(gnt), 32'b0001);
        end
`endif

        // random traffic; requests are sticky half the time so grants last
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(1, 0) == 1) r = 4'($urandom);
            step(r, 4'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        n_fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 multiplexer datapath between four requesters. It registers a one-hot grant and drives the mux select `sel` from it. The granted requester's data bit is routed through an instantiated `MUX_4` to `y`. The block sits between the requesting sources and the shared 1-bit output line.

## Interface
- `HOLD_MAX`, 8: maximum consecutive cycles one owner may hold the grant while others wait. Range 2..255. Used only when `ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high. Clears all state immediately, independent of `clk`.
- `req`  in  4  request per requester; level-sensitive, held high while the requester wants the line.
- `d`  in  4  data bit per requester; `d[i]` belongs to requester i.
- `gnt`  out  4  registered one-hot grant; all-zero when idle.
- `sel`  out  2  registered index of the current or last owner; drives `MUX_4` `S`.
- `busy`  out  1  registered; high while in GRANT.
- `y`  out  1  `MUX_4` output with `I=d`, `S=sel`, ANDed with `busy`; 0 when idle.

## Operation
- **State:** FSM `{IDLE, GRANT}`, plus:
  - `ptr[1:0]`: next search start.
  - `own[1:0]`: current owner; `own` is `sel`.
  - `cnt[7:0]`: hold counter, present only with the macro.
- **Round-robin pick:** scan `req` at indices `ptr, ptr+1, ptr+2, ptr+3`, all mod 4. The first set bit wins. Only requesters other than the current owner are candidates on a handover.
- **IDLE:**
  - If `req != 0`, go to GRANT. Set `own` to the winner, `gnt = 1<<winner`, and `ptr = winner+1` mod 4.
  - Otherwise stay in IDLE with `gnt = 0`. `sel` holds its last value.
- **GRANT, owner releases** (`req[own]==0`):
  - If another request is pending, hand over in the same edge to the next round-robin winner. There is no idle bubble; stay in GRANT.
  - Otherwise go to IDLE: `gnt = 0`, `busy = 0`.
- **GRANT, owner still requesting:** hold the grant unchanged; see Configuration for timeout.
- **Grant changes:** `ptr` updates only when a new grant is issued. Requests that arrive mid-grant wait; they never preempt except via timeout.
- **`y`:** `y = busy & d[sel]`. This path is combinational from `d` and the registered `sel`/`busy`.
- **Reset values:** `gnt=0`, `sel=0`, `busy=0`, `y=0`, `ptr=0`, `cnt=0`, state IDLE.
- **Reset mid-grant:** the grant drops immediately and asynchronously. After deassertion, the first arbitration searches from index 0.

## Timing
- **Grant latency:** a `req` sampled high at edge N (block in IDLE) gives `gnt`/`sel`/`busy` valid after edge N. That is one cycle from `req` to grant.
- **Release latency:** the owner's `req` sampled low at edge N changes `gnt` after edge N, either to the next owner or to zero.
- **`y` timing:** `y` follows `d[sel]` combinationally within the same cycle.
- **Simultaneous requests:** only the round-robin winner is granted. A requester that re-raises `req` right after release is considered only after all pending requesters later in the rotation.
- **Owner drops while another raises `req` in the same cycle:** the new request is visible at that edge and is eligible for the handover.
- **Grant invariant:** `gnt` is never multi-hot, and `gnt[i]` implies `sel==i`.

## Configuration
- **Macro:** `ARB_TIMEOUT_EN`.
- **Defined:**
  - `cnt` clears on every new grant and increments each GRANT cycle.
  - When `cnt == HOLD_MAX-1` and any other requester is pending, the next edge forces a handover to the round-robin winner, even though `req[own]` is still high.
  - The preempted requester re-enters the rotation normally.
  - If nobody else is pending, `cnt` saturates at `HOLD_MAX-1` and the owner keeps the grant.
  - Maximum continuous hold while others wait is `HOLD_MAX` cycles.
- **Not defined:** no `cnt` logic exists, and an owner holds the grant indefinitely while `req` stays high.

## Test plan
- **Reset then single request:** `req=0100` → one cycle later `gnt=0100`, `sel=2`, `busy=1`. Toggling `d[2]` appears on `y` while `d[0,1,3]` are ignored. Dropping `req` → `gnt=0`, `y=0`.
- **All request, each drops after 3 cycles:** `req=1111` from reset; each owner drops its request after 3 cycles of grant, then re-raises it. Grant order is 0,1,2,3,0 with zero-cycle handovers, and `busy` stays high throughout.
- **Async reset mid-grant:** assert `rst` between clock edges while `gnt=0010` → `gnt=0`, `sel=0`, `busy=0` immediately. After deassertion, `req=1010` → grant goes to index 1.
- **Fairness after release:** owner 3 releases while `req=1001` → grant goes to 0. Requester 3 re-raising is not granted before 1 or 2 if they are pending.
- **With `ARB_TIMEOUT_EN`, `HOLD_MAX=4`:** `req[0]` held high and `req[1]` raised in the first granted cycle → `gnt=0001` for exactly 4 cycles, then `0010`. `req[0]` alone for 10 cycles → grant never drops.
- **One-hot assertion:** an always-on check that `gnt` is one-hot or zero and matches `sel`, run with 10k cycles of random `req`/`d`.
